// File: rtl/draw_pkg.sv
// Shared types and constants for the rectangle rasteriser.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/rect_bounds.sv
// Normalises a corner pair into min/max bounds using unsigned compares.
module rect_bounds #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 8
) (
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [X_W-1:0] x1_i,
  input  logic [Y_W-1:0] y1_i,
  output logic [X_W-1:0] xmin_o,
  output logic [X_W-1:0] xmax_o,
  output logic [Y_W-1:0] ymin_o,
  output logic [Y_W-1:0] ymax_o
);

  // Order each axis independently.
  always_comb begin
    xmin_o = (x0_i < x1_i) ? x0_i : x1_i;
    xmax_o = (x0_i < x1_i) ? x1_i : x0_i;
    ymin_o = (y0_i < y1_i) ? y0_i : y1_i;
    ymax_o = (y0_i < y1_i) ? y1_i : y0_i;
  end

endmodule

// File: rtl/draw_rect_raster.sv
// Rectangle rasteriser: latches a corner pair and streams pixel coordinates in
// row-major order over a valid/ready plot interface, filled or outline.
module draw_rect_raster
  import draw_pkg::*;
#(
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                mode,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                abort,
  input  logic                plot_ready,
  output logic                plot,
  output logic [X_W-1:0]      out_x,
  output logic [Y_W-1:0]      out_y,
  output logic [COLOUR_W-1:0] out_colour,
  output logic                busy,
  output logic                done
);

  state_e                state_q, state_d;
  logic [X_W-1:0]        xmin_q, xmin_d, xmax_q, xmax_d, cur_x_q, cur_x_d;
  logic [Y_W-1:0]        ymin_q, ymin_d, ymax_q, ymax_d, cur_y_q, cur_y_d;
  logic                  mode_q, mode_d;
  logic [COLOUR_W-1:0]   colour_q, colour_d;

  logic [X_W-1:0]        in_xmin, in_xmax;
  logic [Y_W-1:0]        in_ymin, in_ymax;

  rect_bounds #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_bounds (
    .x0_i   (x0),
    .y0_i   (y0),
    .x1_i   (x1),
    .y1_i   (y1),
    .xmin_o (in_xmin),
    .xmax_o (in_xmax),
    .ymin_o (in_ymin),
    .ymax_o (in_ymax)
  );

  // Next-state and pixel walk; end of row/rectangle found by equality so
  // bounds at the top of the coordinate range never wrap.
  always_comb begin
    state_d  = state_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    mode_d   = mode_q;
    colour_d = colour_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;

    unique case (state_q)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          xmin_d   = in_xmin;
          xmax_d   = in_xmax;
          ymin_d   = in_ymin;
          ymax_d   = in_ymax;
          mode_d   = mode;
          colour_d = colour;
          cur_x_d  = in_xmin;
          cur_y_d  = in_ymin;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (plot_ready) begin
          if (cur_x_q != xmax_q) begin
            if (mode_q == MODE_FILL || cur_y_q == ymin_q || cur_y_q == ymax_q) begin
              cur_x_d = cur_x_q + X_W'(1);
            end else begin
              // outline interior row: only the two edge pixels
              cur_x_d = xmax_q;
            end
          end else if (cur_y_q != ymax_q) begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + Y_W'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      mode_q   <= 1'b0;
      colour_q <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
    end
  end

  // Outputs decoded straight from state so reset clears them immediately.
  always_comb begin
    plot       = (state_q == RUN);
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    out_x      = cur_x_q;
    out_y      = cur_y_q;
    out_colour = colour_q;
  end

endmodule
